// File: rtl/wwm_pkg.sv
// Shared constants for the World War Math game-flow controller: one-hot
// state encoding and screen geometry.
package wwm_pkg;

  typedef enum logic [3:0] {
    ST_I       = 4'b0001,
    ST_P1SHOOT = 4'b0010,
    ST_ANIMATE = 4'b0100,
    ST_DONE    = 4'b1000
  } state_e;

  localparam int GROUND_Y  = 472;
  localparam int X_MAX     = 639;
  localparam int X_INITIAL = 213;
  localparam int Y_INITIAL = 472;

endpackage

// File: rtl/wwm_btn_edge.sv
// Registers a raw button level and flags a rising edge between the last two
// samples; both samples reset high so a button held through reset is not a press.
module wwm_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic cur_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      cur_q  <= btn_i;
      prev_q <= cur_q;
    end
  end

  assign press_o = cur_q & ~prev_q;

endmodule

// File: rtl/wwm_state_machine.sv
// Game-flow controller: Idle -> P1Shoot -> Animate -> Done -> Idle, advanced by
// button presses and by the projectile landing, leaving the screen or timing out.
module wwm_state_machine
  import wwm_pkg::*;
#(
  parameter int GROUND_Y     = wwm_pkg::GROUND_Y,
  parameter int X_MAX        = wwm_pkg::X_MAX,
  parameter int ANIM_TIMEOUT = 200000000,
  parameter int CNT_W        = 28
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Fire,
  input  logic       Ack,
  input  logic [3:0] vX,
  input  logic [3:0] vY,
  input  logic [9:0] projectileCenterX,
  input  logic [9:0] projectileCenterY,
  output logic       q_I,
  output logic       q_P1Shoot,
  output logic       q_Animate,
  output logic       q_Done
);

  logic start_p, fire_p, ack_p;

  wwm_btn_edge u_start (.clk(clk), .rst(Reset), .btn_i(Start), .press_o(start_p));
  wwm_btn_edge u_fire  (.clk(clk), .rst(Reset), .btn_i(Fire),  .press_o(fire_p));
  wwm_btn_edge u_ack   (.clk(clk), .rst(Reset), .btn_i(Ack),   .press_o(ack_p));

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               air_q, air_d;
  logic               below_ground, landed, off_right, timed_out;

  assign below_ground = projectileCenterY < 10'(GROUND_Y);
  assign landed       = air_q && !below_ground;
  assign off_right    = projectileCenterX >= 10'(X_MAX);
  assign timed_out    = cnt_q == CNT_W'(ANIM_TIMEOUT - 1);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_I;
      cnt_q   <= '0;
      air_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      air_q   <= air_d;
    end
  end

  // Counter and airborne flag only run in Animate, so they are already clear on entry.
  always_comb begin
    cnt_d = '0;
    air_d = 1'b0;
    if (state_q == ST_ANIMATE) begin
      cnt_d = cnt_q + 1'b1;
      air_d = air_q | below_ground;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_I:       if (start_p) state_d = ST_P1SHOOT;
      ST_P1SHOOT: if (fire_p && ({vX, vY} != 8'd0)) state_d = ST_ANIMATE;
      ST_ANIMATE: if (landed || off_right || timed_out) state_d = ST_DONE;
      ST_DONE:    if (ack_p) state_d = ST_I;
      default:    state_d = ST_I;
    endcase
  end

  always_comb begin
    {q_Done, q_Animate, q_P1Shoot, q_I} = state_q;
  end

endmodule

// File: tb/tb_wwm_state_machine.sv
// Bench for wwm_state_machine: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the game flow.
module tb_wwm_state_machine;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       Reset, Start, Fire, Ack;
  logic [3:0] vX, vY;
  logic [9:0] pX, pY;
  logic       q_I, q_P1Shoot, q_Animate, q_Done;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  wwm_state_machine #(.GROUND_Y(472), .X_MAX(639), .ANIM_TIMEOUT(TO), .CNT_W(28)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .Fire(Fire), .Ack(Ack),
    .vX(vX), .vY(vY), .projectileCenterX(pX), .projectileCenterY(pY),
    .q_I(q_I), .q_P1Shoot(q_P1Shoot), .q_Animate(q_Animate), .q_Done(q_Done)
  );

  // Model: 0=Idle 1=P1Shoot 2=Animate 3=Done; button levels seen at the last two edges.
  int   m_st, m_age;
  logic m_air;
  logic [2:0] seen1, seen0;

  function automatic logic [3:0] outs();
    return {q_Done, q_Animate, q_P1Shoot, q_I};
  endfunction

  function automatic logic [3:0] m_outs();
    return 4'b0001 << m_st;
  endfunction

  task automatic model_reset();
    m_st = 0; m_age = 0; m_air = 1'b0;
    seen1 = 3'b111; seen0 = 3'b111;
  endtask

  task automatic model_edge();
    logic [2:0] pressed;
    if (Reset) begin
      model_reset();
      return;
    end
    pressed = seen1 & ~seen0;
    case (m_st)
      0: if (pressed[0]) m_st = 1;
      1: if (pressed[1] && (vX != 0 || vY != 0)) begin
           m_st = 2; m_age = 0; m_air = 1'b0;
         end
      2: if ((m_air && pY >= 472) || pX >= 639 || m_age == TO - 1) m_st = 3;
         else begin
           m_age++;
           if (pY < 472) m_air = 1'b1;
         end
      default: if (pressed[2]) m_st = 0;
    endcase
    seen0 = seen1;
    seen1 = {Ack, Fire, Start};
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Raise one button for the two cycles press detection needs, then drop it.
  task automatic press(input int which);
    case (which)
      0: Start = 1'b1;
      1: Fire  = 1'b1;
      default: Ack = 1'b1;
    endcase
    tick(); tick();
    Start = 1'b0; Fire = 1'b0; Ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; Fire = 1'b0; Ack = 1'b0;
    vX = 0; vY = 0; pX = 10'd213; pY = 10'd472;
    model_reset();
    tick(); tick();
    chk_cnt++;
    if (outs() !== 4'b0001) $display("FAIL reset_state got %b want 0001", outs());
    else pass_cnt++;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if (outs() !== 4'b0001) $display("FAIL held_start_after_reset cyc %0d got %b want 0001", i, outs());
      else pass_cnt++;
    end
    Start = 1'b0;
    tick(); tick();
    Start = 1'b1;
    tick();
    chk_cnt++;
    if (outs() !== 4'b0001) $display("FAIL start_lat1 got %b want 0001", outs());
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (outs() !== 4'b0010) $display("FAIL start_lat2 got %b want 0010", outs());
    else pass_cnt++;
    Start = 1'b0;
    tick();
  endtask

  task automatic test_fire();
    vX = 0; vY = 0;
    press(1);
    tick();
    chk_cnt++;
    if (outs() !== 4'b0010) $display("FAIL zero_velocity_fire got %b want 0010", outs());
    else pass_cnt++;
    vX = 4'd5; vY = 4'd9;
    Fire = 1'b1;
    tick(); tick();
    chk_cnt++;
    if (outs() !== 4'b0100) $display("FAIL fire_to_animate got %b want 0100", outs());
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_cnt++;
      if (outs() !== 4'b0100) $display("FAIL fire_held cyc %0d got %b want 0100", i, outs());
      else pass_cnt++;
    end
    Fire = 1'b0;
  endtask

  task automatic test_landing();
    pY = 10'd472;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_cnt++;
      if (outs() !== 4'b0100) $display("FAIL ground_at_launch cyc %0d got %b want 0100", i, outs());
      else pass_cnt++;
    end
    pY = 10'd400;
    tick();
    chk_cnt++;
    if (outs() !== 4'b0100) $display("FAIL airborne got %b want 0100", outs());
    else pass_cnt++;
    pY = 10'd472;
    tick();
    chk_cnt++;
    if (outs() !== 4'b1000) $display("FAIL landed got %b want 1000", outs());
    else pass_cnt++;
    press(2);
    chk_cnt++;
    if (outs() !== 4'b0001) $display("FAIL ack_after_land got %b want 0001", outs());
    else pass_cnt++;
  endtask

  task automatic test_offscreen();
    press(0);
    pX = 10'd630; pY = 10'd300;
    press(1);
    for (int x = 631; x <= 639; x++) begin
      chk_cnt++;
      if (outs() !== 4'b0100) $display("FAIL offscreen_pre x %0d got %b want 0100", x - 1, outs());
      else pass_cnt++;
      pX = 10'(x);
      tick();
    end
    chk_cnt++;
    if (outs() !== 4'b1000) $display("FAIL offscreen got %b want 1000", outs());
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    press(2);
    press(0);
    pX = 10'd213; pY = 10'd472;
    Fire = 1'b1;
    tick(); tick();
    Fire = 1'b0;
    n = 0;
    while (q_Done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk_cnt++;
    if (n !== TO) $display("FAIL timeout_cycles got %0d want %0d", n, TO);
    else pass_cnt++;
    press(0);
    press(1);
    chk_cnt++;
    if (outs() !== 4'b1000) $display("FAIL done_ignores_start_fire got %b want 1000", outs());
    else pass_cnt++;
    press(2);
    chk_cnt++;
    if (outs() !== 4'b0001) $display("FAIL ack_to_idle got %b want 0001", outs());
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    press(0);
    pY = 10'd300; pX = 10'd300;
    press(1);
    tick();
    chk_cnt++;
    if (outs() !== 4'b0100) $display("FAIL pre_reset_animate got %b want 0100", outs());
    else pass_cnt++;
    #2 Reset = 1'b1;
    #1;
    chk_cnt++;
    if (outs() !== 4'b0001) $display("FAIL async_reset got %b want 0001", outs());
    else pass_cnt++;
    model_reset();
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      Start = ($urandom_range(0, 3) == 0);
      Fire  = ($urandom_range(0, 3) == 0);
      Ack   = ($urandom_range(0, 3) == 0);
      vX = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      vY = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      pX = 10'($urandom_range(0, 9) == 0 ? $urandom_range(630, 700) : $urandom_range(0, 600));
      pY = 10'($urandom_range(0, 1) == 0 ? $urandom_range(465, 480) : $urandom_range(0, 464));
      tick();
      chk_cnt++;
      if (outs() !== m_outs()) $display("FAIL random cyc %0d got %b want %b", i, outs(), m_outs());
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_fire();
    test_landing();
    test_offscreen();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
